// File: rtl/cpu_sequencer.sv
// cpu_sequencer: four-cycle FETCH/DECODE/EXECUTE/WRITEBACK control for the 8-bit core.
// Owns pc, ir and the retired counter; every strobe is decoded from registered state only.
module cpu_sequencer #(
  parameter int PC_W   = 4,
  parameter int INSN_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic [INSN_W-1:0] instr,
  input  logic              alu_zero,
  output logic [PC_W-1:0]   pc,
  output logic [INSN_W-1:0] ir,
  output logic              ir_load,
  output logic [2:0]        alu_op,
  output logic              reg_write,
  output logic              pc_src,
  output logic              retired,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  // state       | meaning
  // S_IDLE      | waiting for run or step (blocked while halt_req is high)
  // S_FETCH     | pc presented to instruction memory
  // S_DECODE    | instr captured into ir
  // S_EXECUTE   | alu_op driven, alu_zero sampled into zero_q
  // S_WRITEBACK | strobes, pc update, retire
  // S_HALTED    | HLT executed; only reset leaves this state
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALTED
  } state_t;

  state_t state, state_nxt;
  logic   mode_free;
  logic   zero_q;
  logic   start;
  logic   is_alu, is_bz, is_jmp, is_hlt, taken;

  assign is_alu = (ir[INSN_W-1 -: 2] == 2'b00);
  assign is_bz  = (ir[INSN_W-1 -: 2] == 2'b10);
  assign is_jmp = (ir[INSN_W-1 -: 2] == 2'b11) && !ir[5];
  assign is_hlt = (ir[INSN_W-1 -: 2] == 2'b11) &&  ir[5];
  assign taken  = is_jmp || (is_bz && zero_q);
  assign start  = !halt_req && (run || step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH;
      S_FETCH:     state_nxt = S_DECODE;
      S_DECODE:    state_nxt = S_EXECUTE;
      S_EXECUTE:   state_nxt = S_WRITEBACK;
      S_WRITEBACK: begin
        if (is_hlt)                            state_nxt = S_HALTED;
        else if (mode_free && run && !halt_req) state_nxt = S_FETCH;
        else                                   state_nxt = S_IDLE;
      end
      S_HALTED:    state_nxt = S_HALTED;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
      mode_free   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      // run wins over step when both are high at the start
      if (state == S_IDLE && start) mode_free <= run;
      if (state == S_DECODE)        ir        <= instr;
      if (state == S_EXECUTE)       zero_q    <= alu_zero;
      if (state == S_WRITEBACK) begin
        instr_count <= instr_count + CNT_W'(1);
        if (taken)        pc <= ir[PC_W-1:0];
        else if (!is_hlt) pc <= pc + PC_W'(1);
      end
    end
  end

  always_comb begin
    ir_load   = (state == S_DECODE);
    alu_op    = 3'd0;
    if ((state == S_EXECUTE || state == S_WRITEBACK) && is_alu) alu_op = ir[5:3];
    reg_write = (state == S_WRITEBACK) && is_alu;
    pc_src    = (state == S_WRITEBACK) && taken;
    retired   = (state == S_WRITEBACK);
    busy      = (state != S_IDLE) && (state != S_HALTED);
    halted    = (state == S_HALTED);
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 8-bit processor core. It owns the 4-bit program counter and the instruction register, and steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK. Along the way it drives the ALU operation select, the register-file write strobe and the branch select into the existing datapath. Run, single-step and halt controls let the Tiny Tapeout wrapper free-run the core or advance it one instruction at a time.

## Interface
- PC_W, 4, program counter / instruction-memory address width
- INSN_W, 8, instruction width; opcode is bits [7:6]
- CNT_W, 8, retired-instruction counter width

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  level; high = free-run instructions
- step  in  1  one-cycle pulse; execute exactly one instruction from IDLE
- halt_req  in  1  level; stop at next instruction boundary
- instr  in  INSN_W  instruction-memory read data, valid the cycle after pc is presented
- alu_zero  in  1  datapath ALU zero flag
- pc  out  PC_W  instruction fetch address
- ir  out  INSN_W  instruction register
- ir_load  out  1  IR capture strobe
- alu_op  out  3  ALU operation select
- reg_write  out  1  register-file write enable
- pc_src  out  1  high in WRITEBACK of a taken branch/jump
- retired  out  1  one-cycle pulse per completed instruction
- busy  out  1  state is not IDLE/HALTED
- halted  out  1  state is HALTED
- instr_count  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- Reset (async, rst_n low) puts the block in IDLE with:
  - pc = 0, ir = 0, instr_count = 0;
  - alu_op = 0;
  - all strobes, busy and halted = 0;
  - the mode flag and the internal zero flag cleared.
- IDLE:
  - run = 1 → FETCH, mode = free-run.
  - Otherwise step = 1 → FETCH, mode = single.
  - run wins if both are high.
  - halt_req = 1 blocks both.
- FETCH: pc is presented; no strobes asserted.
- DECODE: ir_load = 1; ir <= instr.
- EXECUTE:
  - alu_op = ir[5:3] when opcode 00, else 0.
  - alu_zero is registered into the internal zero flag.
- WRITEBACK:
  - Decode of the instruction:
    - 00 ALU: alu_op held; reg_write = 1.
    - 01: NOP.
    - 10 BZ: taken if the zero flag = 1.
    - 11 with ir[5] = 0 JMP: always taken.
    - 11 with ir[5] = 1 HLT.
  - pc update: taken → pc <= ir[3:0] and pc_src = 1. HLT → pc unchanged. Otherwise pc <= pc+1, wrapping 15 → 0.
  - retired = 1, instr_count += 1, wrapping 255 → 0. HLT counts as retired.
- Next state after WRITEBACK:
  - HLT → HALTED.
  - free-run and run = 1 and halt_req = 0 → FETCH.
  - else → IDLE.
- HALTED: sticky; exits only via reset; run and step are ignored.
- step pulses outside IDLE are ignored, not queued.
- run deasserting or halt_req asserting mid-instruction never aborts it; the current instruction completes through WRITEBACK.

## Timing
- Fixed 4 cycles per instruction; free-run throughput is 1 instruction per 4 cycles with no bubble between WRITEBACK and the next FETCH.
- step sampled high in IDLE at edge t:
  - FETCH at t+1, DECODE at t+2, EXECUTE at t+3, WRITEBACK at t+4;
  - back in IDLE at t+5.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- instr must be valid in DECODE: one-cycle synchronous memory latency from pc.
- alu_zero is sampled only at the EXECUTE edge; later changes do not affect the branch.
- reg_write, pc_src and retired are high for exactly one cycle, all in WRITEBACK.
- Reset asserted in any state takes effect immediately; no partial write strobe is produced after rst_n falls.

## Test plan
- Reset then single step:
  - Setup: release reset; instr = 8'b00_011_000; pulse step once.
  - Expected: ir_load in cycle 2, alu_op = 3 in EXECUTE/WRITEBACK, reg_write and retired in cycle 4, pc = 1, instr_count = 1, then IDLE with busy = 0.
- Free-run wrap:
  - Setup: run = 1 with NOP at all addresses for 16 instructions.
  - Expected: pc goes 0..15 then 0; retired every 4 cycles; instr_count = 16.
- Branch:
  - Setup: BZ 8'b10_00_0111 with alu_zero = 1 in EXECUTE; repeat with alu_zero = 0.
  - Expected: first run pc = 7 and pc_src pulses; second run pc = pc+1 and pc_src stays 0.
  - Also: alu_zero toggled in WRITEBACK only does not change the outcome.
- HLT:
  - Setup: execute 8'b11_1_00000 at pc = 5 under run.
  - Expected: halted = 1, pc stays 5, instr_count increments.
  - Then: step and run pulses give no further activity until rst_n is low.
- halt_req and run drop:
  - Setup: assert halt_req in DECODE under run.
  - Expected: the instruction completes (retired pulses), then IDLE.
  - Also: step while busy is ignored; run and step together in IDLE start free-run.
- Async reset mid-instruction:
  - Setup: drop rst_n in WRITEBACK off the clock edge.
  - Expected: all outputs go to reset values immediately; count wrap 255 → 0 verified by forcing 256 retirements.
